i2c_target_rx: RTL and testbench



---
 rtl/i2c_target_rx.sv | 126 ++++++++++++
 tb/tb_i2c_target_rx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_rx.sv
// i2c_target_rx: I2C target write receiver; ACKs its own write address and deserialises data bytes.
module i2c_target_rx #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       data_ack,
    output logic       addr_match,
    output logic       busy,
    output logic       stop_det,
    output logic       nack_sent
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;
    state_t state, state_n;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_q, sda_q, scl_s, sda_s;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n, rx_data_n;
    logic full, full_n, pend, pend_n, acked, acked_n;
    logic sda_oe_n, addr_match_n, busy_n, stop_det_n, nack_sent_n;
    logic scl_rise, scl_fall, start, stop;
    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_q;
    assign scl_fall = ~scl_s & scl_q;
    assign start    = scl_s & scl_q & sda_q & ~sda_s;
    assign stop     = scl_s & scl_q & ~sda_q & sda_s;
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        full_n       = full;
        acked_n      = acked;
        pend_n       = 1'b0;
        sda_oe_n     = sda_oe;
        addr_match_n = addr_match;
        busy_n       = busy;
        stop_det_n   = 1'b0;
        nack_sent_n  = 1'b0;
        rx_data_n    = pend ? shift : rx_data;
        if (start) begin
            state_n      = ADDR;
            bit_cnt_n    = 3'd0;
            full_n       = 1'b0;
            busy_n       = 1'b1;
            sda_oe_n     = 1'b0;
            addr_match_n = 1'b0;
        end else if (stop) begin
            state_n      = IDLE;
            bit_cnt_n    = 3'd0;
            full_n       = 1'b0;
            busy_n       = 1'b0;
            sda_oe_n     = 1'b0;
            addr_match_n = 1'b0;
            stop_det_n   = 1'b1;
        end else if ((state == ADDR || state == DATA) && scl_rise && !full) begin
            shift_n   = {shift[6:0], sda_s};
            full_n    = bit_cnt == 3'd7;
            bit_cnt_n = bit_cnt == 3'd7 ? bit_cnt : bit_cnt + 3'd1;
            pend_n    = state == DATA && bit_cnt == 3'd7;
        end else if (scl_fall) begin
            // Each fall either closes a full byte or ends an ACK slot.
            if (state == ADDR && full) begin
                full_n       = 1'b0;
                sda_oe_n     = shift == {SLAVE_ADDR, 1'b0};
                addr_match_n = shift == {SLAVE_ADDR, 1'b0};
                state_n      = shift == {SLAVE_ADDR, 1'b0} ? ADDR_ACK : IGNORE;
            end else if (state == DATA && full) begin
                full_n      = 1'b0;
                sda_oe_n    = data_ack;
                acked_n     = data_ack;
                nack_sent_n = ~data_ack;
                state_n     = DATA_ACK;
            end else if (state == ADDR_ACK || state == DATA_ACK) begin
                sda_oe_n  = 1'b0;
                bit_cnt_n = 3'd0;
                state_n   = (state == ADDR_ACK || acked) ? DATA : IGNORE;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_sync   <= '1;
            sda_sync   <= '1;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            full       <= 1'b0;
            pend       <= 1'b0;
            acked      <= 1'b0;
            sda_oe     <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            addr_match <= 1'b0;
            busy       <= 1'b0;
            stop_det   <= 1'b0;
            nack_sent  <= 1'b0;
        end else begin
            scl_sync   <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync   <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_q      <= scl_s;
            sda_q      <= sda_s;
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            full       <= full_n;
            pend       <= pend_n;
            acked      <= acked_n;
            sda_oe     <= sda_oe_n;
            rx_data    <= rx_data_n;
            rx_valid   <= pend;
            addr_match <= addr_match_n;
            busy       <= busy_n;
            stop_det   <= stop_det_n;
            nack_sent  <= nack_sent_n;
        end
    end
endmodule

// File: tb/tb_i2c_target_rx.sv
// tb_i2c_target_rx: drives a bit-banged I2C master against i2c_target_rx and checks table-driven transfers.
module tb_i2c_target_rx;
    localparam int Q = 5;
    localparam int H = 10;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic data_ack = 1'b1;
    logic sda_in, sda_oe, rx_valid, addr_match, busy, stop_det, nack_sent;
    logic [7:0] rx_data;
    int n_chk = 0;
    int n_fail = 0;
    int rx_cnt = 0;
    int nack_cnt = 0;
    int stop_cnt = 0;
    logic [7:0] rx_log [64];

    assign sda_in = sda_m & ~sda_oe;

    i2c_target_rx dut (
        .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_in), .sda_oe(sda_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .data_ack(data_ack), .addr_match(addr_match),
        .busy(busy), .stop_det(stop_det), .nack_sent(nack_sent)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rx_cnt % 64] = rx_data;
            rx_cnt = rx_cnt + 1;
        end
        if (nack_sent) nack_cnt = nack_cnt + 1;
        if (stop_det) stop_cnt = stop_cnt + 1;
    end

    typedef struct {
        logic [7:0] addr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       ack;
        logic       exp_aack;
        logic       exp_k0;
        logic       exp_k1;
        int         exp_nv;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
        int         exp_nack;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, output logic oe);
        sda_m = b;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(H / 2);
        oe = sda_oe;
        wait_clk(H / 2);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic d;
        for (int i = 7; i >= 0; i--) send_bit(b[i], d);
        send_bit(1'b1, ack);
    endtask

    task automatic do_start();
        sda_m = 1'b0;
        wait_clk(H);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic do_rstart();
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(H);
        do_start();
    endtask

    task automatic do_stop();
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(H);
        sda_m = 1'b1;
        wait_clk(H);
    endtask

    initial begin
        logic a, k0, k1, d;
        int nv0, nk0, ns0;
        vecs[0] = '{8'hA0, 8'h3C, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 2, 8'h3C, 8'hC3, 0};
        vecs[1] = '{8'hA2, 8'h3C, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'h00, 8'h00, 0};
        vecs[2] = '{8'hA1, 8'h3C, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 8'h00, 8'h00, 0};
        vecs[3] = '{8'hA0, 8'h55, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 1, 8'h55, 8'h55, 1};
        vecs[4] = '{8'hA0, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 2, 8'h00, 8'hFF, 0};
        wait_clk(4);
        check("rst sda_oe", {31'd0, sda_oe}, 0);
        check("rst rx_data", {24'd0, rx_data}, 0);
        check("rst rx_valid", {31'd0, rx_valid}, 0);
        check("rst addr_match", {31'd0, addr_match}, 0);
        check("rst busy", {31'd0, busy}, 0);
        check("rst stop_det", {31'd0, stop_det}, 0);
        check("rst nack_sent", {31'd0, nack_sent}, 0);
        reset = 1'b1;
        wait_clk(10);

        foreach (vecs[v]) begin
            nv0 = rx_cnt; nk0 = nack_cnt; ns0 = stop_cnt;
            data_ack = vecs[v].ack;
            do_start();
            check($sformatf("v%0d busy_start", v), {31'd0, busy}, 1);
            send_byte(vecs[v].addr, a);
            check($sformatf("v%0d addr_ack", v), {31'd0, a}, {31'd0, vecs[v].exp_aack});
            check($sformatf("v%0d addr_match", v), {31'd0, addr_match}, {31'd0, vecs[v].exp_aack});
            send_byte(vecs[v].d0, k0);
            check($sformatf("v%0d ack0", v), {31'd0, k0}, {31'd0, vecs[v].exp_k0});
            send_byte(vecs[v].d1, k1);
            check($sformatf("v%0d ack1", v), {31'd0, k1}, {31'd0, vecs[v].exp_k1});
            check($sformatf("v%0d busy_pre_stop", v), {31'd0, busy}, 1);
            do_stop();
            check($sformatf("v%0d rx_count", v), rx_cnt - nv0, vecs[v].exp_nv);
            check($sformatf("v%0d nack_count", v), nack_cnt - nk0, vecs[v].exp_nack);
            check($sformatf("v%0d stop_count", v), stop_cnt - ns0, 1);
            check($sformatf("v%0d busy_end", v), {31'd0, busy}, 0);
            check($sformatf("v%0d match_end", v), {31'd0, addr_match}, 0);
            if (vecs[v].exp_nv > 0) begin
                check($sformatf("v%0d first", v), {24'd0, rx_log[nv0 % 64]}, {24'd0, vecs[v].exp_first});
                check($sformatf("v%0d rx_data", v), {24'd0, rx_data}, {24'd0, vecs[v].exp_last});
            end
            wait_clk(10);
        end

        nv0 = rx_cnt;
        data_ack = 1'b1;
        do_start();
        send_byte(8'hA0, a);
        send_byte(8'h11, k0);
        do_rstart();
        check("rs match_drop", {31'd0, addr_match}, 0);
        check("rs busy", {31'd0, busy}, 1);
        send_byte(8'hA0, a);
        check("rs addr_ack", {31'd0, a}, 1);
        check("rs match_again", {31'd0, addr_match}, 1);
        send_byte(8'h22, k1);
        do_stop();
        check("rs rx_count", rx_cnt - nv0, 2);
        check("rs first", {24'd0, rx_log[nv0 % 64]}, 32'h11);
        check("rs second", {24'd0, rx_log[(nv0 + 1) % 64]}, 32'h22);
        wait_clk(10);

        do_start();
        send_byte(8'hA0, a);
        for (int i = 0; i < 3; i++) send_bit(1'b0, d);
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mrst sda_oe", {31'd0, sda_oe}, 0);
        check("mrst rx_data", {24'd0, rx_data}, 0);
        check("mrst busy", {31'd0, busy}, 0);
        check("mrst addr_match", {31'd0, addr_match}, 0);
        check("mrst flags", {29'd0, rx_valid, stop_det, nack_sent}, 0);
        wait_clk(4);
        sda_m = 1'b1;
        scl_m = 1'b1;
        wait_clk(4);
        reset = 1'b1;
        wait_clk(10);
        nv0 = rx_cnt;
        do_start();
        send_byte(8'hA0, a);
        check("post addr_ack", {31'd0, a}, 1);
        send_byte(8'h7E, k0);
        do_stop();
        check("post rx_count", rx_cnt - nv0, 1);
        check("post rx_data", {24'd0, rx_data}, 32'h7E);
        wait_clk(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
